char_sweep_ctrl: RTL
====================

CHAR_SWEEP_CTRL -- requirements
Module: char_sweep_ctrl

Interface
REQ-001 Parameter NB_SLOPES, 7, number of input-slope points in the sweep.
REQ-002 Parameter NB_CAPA, 7, number of load-capacitance points in the sweep.
REQ-003 Parameter TICK_CYCLES, 7, settle length of every sweep phase in clock cycles (legal range 2..255).
REQ-004 Parameter CNT_W, 8, width of the propagation-time result.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle request to run a full sweep.
REQ-008 dout_meas  in  1  synchronous sampled inverter output.
REQ-009 busy  out  1  high from the cycle after accepted start until DONE is left.
REQ-010 done  out  1  one-cycle pulse at sweep end.
REQ-011 err  out  1  sticky, set on any measurement timeout, cleared on accepted start.
REQ-012 slope_idx  out  3  current slope-table index for the analog stimulus model.
REQ-013 capa_idx  out  3  current capacitance-table index.
REQ-014 cfg_valid  out  1  one-cycle pulse when slope_idx or capa_idx changes.
REQ-015 din  out  1  stimulus to the inverter under test.
REQ-016 res_wr_en  out  1  one-cycle result-write strobe.
REQ-017 res_addr  out  6  result address = slope_idx*NB_CAPA + capa_idx.
REQ-018 res_data  out  CNT_W  measured propagation time in clock cycles.

Function
REQ-019 FSM states SHALL be IDLE, SET_SLOPE, SET_CAPA, RISE, FALL, DONE; every state except IDLE and DONE SHALL last exactly TICK_CYCLES cycles, timed by a tick counter reloaded on every state entry.
REQ-020 IDLE + start=1 SHALL go to SET_SLOPE with slope_idx=0, capa_idx=0; start while busy SHALL be ignored.
REQ-021 On SET_SLOPE entry slope_idx SHALL update and cfg_valid pulse; on completion go to SET_CAPA.
REQ-022 On SET_CAPA entry capa_idx SHALL update and cfg_valid pulse; on completion go to RISE.
REQ-023 din SHALL be 1 throughout RISE and 0 in all other states.
REQ-024 Measurement: result = k, where k (1..TICK_CYCLES) is the RISE cycle in which dout_meas is first sampled 0; later samples ignored.
REQ-025 If dout_meas never samples 0 during RISE, result SHALL saturate to all-ones and err SHALL set.
REQ-026 On the last RISE cycle res_wr_en SHALL pulse with res_addr and res_data valid in the same cycle; exactly one write per (slope, capa) point.
REQ-027 FALL completion SHALL go to SET_CAPA with capa_idx+1 if capa_idx<NB_CAPA-1; else to SET_SLOPE with slope_idx+1, capa_idx=0 if slope_idx<NB_SLOPES-1; else to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then IDLE; indices hold their final values.
REQ-029 Total sweep length SHALL be NB_SLOPES*(1+3*NB_CAPA)*TICK_CYCLES+1 cycles from accepted start to done (1079 at defaults).

Reset
REQ-030 While rst_n=0 at a clock edge, state SHALL be IDLE and busy, done, err, cfg_valid, din, res_wr_en SHALL be 0; slope_idx, capa_idx, res_addr, res_data, tick and measurement counters SHALL be 0.
REQ-031 Reset mid-sweep SHALL abort immediately with no further result writes; a new start is required.

Structure
REQ-032 Package char_sweep_pkg SHALL hold the state enum and default NB_SLOPES, NB_CAPA, TICK_CYCLES, CNT_W constants.
REQ-033 The phase timer SHALL be a sub-module char_tick_timer (load, count-down, last-cycle flag).

Verification
REQ-034 start, dout_meas falls 3 cycles after din rise every point -> 49 writes, addresses 0..48 in order, all res_data=3, err=0, done at cycle 1079.
REQ-035 dout_meas held 1 at point (2,4) -> res_addr=18, res_data=255, err=1 until next start.
REQ-036 dout_meas already 0 on first RISE cycle -> res_data=1; glitch back to 1 afterwards does not change result.
REQ-037 rst_n=0 during RISE of point (1,0) -> next cycle din=0, busy=0, no res_wr_en; subsequent start restarts at address 0.
REQ-038 start pulsed again while busy -> ignored, sweep order and write count unchanged; cfg_valid pulses exactly 7+49 times per sweep.

Source files
------------

// File: rtl/char_sweep_pkg.sv
// Shared types and default sizing for the
// inverter characterisation sweep controller.
package char_sweep_pkg;

  localparam int DEF_NB_SLOPES   = 7;
  localparam int DEF_NB_CAPA     = 7;
  localparam int DEF_TICK_CYCLES = 7;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_SLOPE,
    S_SET_CAPA,
    S_RISE,
    S_FALL,
    S_DONE
  } state_e;

endpackage

// File: rtl/char_tick_timer.sv
// Phase timer: loadable down-counter with a
// flag marking the last cycle of a phase.
module char_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload on phase entry, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/char_sweep_ctrl.sv
// Sweeps slope x capacitance points, pulses the
// inverter input and records propagation time.
module char_sweep_ctrl
  import char_sweep_pkg::*;
#(
  parameter int NB_SLOPES   = DEF_NB_SLOPES,
  parameter int NB_CAPA     = DEF_NB_CAPA,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dout_meas,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       slope_idx,
  output logic [2:0]       capa_idx,
  output logic             cfg_valid,
  output logic             din,
  output logic             res_wr_en,
  output logic [5:0]       res_addr,
  output logic [CNT_W-1:0] res_data
);

  localparam logic [7:0] TICK_LOAD = 8'(TICK_CYCLES - 1);
  localparam logic [7:0] TICK_LEN  = 8'(TICK_CYCLES);
  localparam logic [2:0] CAPA_MAX  = 3'(NB_CAPA - 1);
  localparam logic [2:0] SLOPE_MAX = 3'(NB_SLOPES - 1);

  state_e     state_q, state_d;
  logic [2:0] slope_q, slope_d;
  logic [2:0] capa_q, capa_d;
  logic       cfg_q, cfg_d;
  logic       err_q, err_d;
  logic       found_q, found_d;
  logic [7:0] meas_q, meas_d;

  logic [7:0]       tick_cnt;
  logic             tick_last;
  logic [7:0]       rise_k;
  logic             timeout;
  logic             in_rise;
  logic [CNT_W-1:0] result;

  char_tick_timer #(
    .W(8)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_d != state_q),
    .load_val (TICK_LOAD),
    .cnt      (tick_cnt),
    .last     (tick_last)
  );

  assign in_rise = (state_q == S_RISE);
  assign rise_k  = TICK_LEN - tick_cnt;
  assign timeout = !found_q && dout_meas;

  // Result of the current point, including this cycle's sample.
  always_comb begin
    result = '1;
    if (found_q) begin
      result = CNT_W'(meas_q);
    end else if (!dout_meas) begin
      result = CNT_W'(rise_k);
    end
  end

  // Capture the first RISE cycle where the output reads low.
  always_comb begin
    found_d = found_q;
    meas_d  = meas_q;
    if (!in_rise) begin
      found_d = 1'b0;
      meas_d  = '0;
    end else if (!found_q && !dout_meas) begin
      found_d = 1'b1;
      meas_d  = rise_k;
    end
  end

  // Next-state, index, config-pulse and error logic.
  always_comb begin
    state_d = state_q;
    slope_d = slope_q;
    capa_d  = capa_q;
    cfg_d   = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SET_SLOPE;
          slope_d = '0;
          capa_d  = '0;
          cfg_d   = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_SET_SLOPE: begin
        if (tick_last) begin
          state_d = S_SET_CAPA;
          cfg_d   = 1'b1;
        end
      end
      S_SET_CAPA: begin
        if (tick_last) begin
          state_d = S_RISE;
        end
      end
      S_RISE: begin
        if (tick_last) begin
          state_d = S_FALL;
          if (timeout) begin
            err_d = 1'b1;
          end
        end
      end
      S_FALL: begin
        if (tick_last) begin
          if (capa_q < CAPA_MAX) begin
            state_d = S_SET_CAPA;
            capa_d  = capa_q + 3'd1;
            cfg_d   = 1'b1;
          end else if (slope_q < SLOPE_MAX) begin
            state_d = S_SET_SLOPE;
            slope_d = slope_q + 3'd1;
            capa_d  = '0;
            cfg_d   = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slope_q <= '0;
      capa_q  <= '0;
      cfg_q   <= 1'b0;
      err_q   <= 1'b0;
      found_q <= 1'b0;
      meas_q  <= '0;
    end else begin
      state_q <= state_d;
      slope_q <= slope_d;
      capa_q  <= capa_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      found_q <= found_d;
      meas_q  <= meas_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign din       = in_rise;
  assign err       = err_q;
  assign cfg_valid = cfg_q;
  assign slope_idx = slope_q;
  assign capa_idx  = capa_q;
  assign res_wr_en = in_rise && tick_last;
  assign res_data  = res_wr_en ? result : '0;
  assign res_addr  = 6'(slope_q) * 6'(NB_CAPA)
                   + 6'(capa_q);

endmodule
